// File: rtl/pc_seq_ctrl_if.sv
// Fetch request/ready handshake between the next-PC sequencer (master)
// and the instruction fetch unit (slave).
interface pc_seq_ctrl_if #(
  parameter int XLEN = 64
);
  logic            fetch_req;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;

  modport master (output fetch_req, output fetch_pc, input fetch_ready);
  modport slave  (input fetch_req, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: owns the fetch PC, drives the IFU handshake, merges
// branch/jump and trap redirects, handles ebreak halt and raises flush.
// Optional performance counters are enabled with `define PC_SEQ_CTRL_PERF_EN.
module pc_seq_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  pc_seq_ctrl_if.master      fetch_if,
  input  logic               br_valid,
  input  logic               pc_src1,
  input  logic               pc_src2,
  input  logic [XLEN-1:0]    br_pc,
  input  logic [XLEN-1:0]    x_rs1,
  input  logic [XLEN-1:0]    imm,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               halt,
  output logic               flush,
  output logic               halted,
  output logic [31:0]        redirect_cnt,
  output logic [31:0]        stall_cnt
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND, ST_HALT} state_t;

  state_t          state_reg, state_next;
  logic            fetch_req_reg, fetch_req_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;

  logic            accept;
  logic            br_redir;
  logic            redir;
  logic [XLEN-1:0] tgt_sum;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] target;

  // Redirect target and arbitration; a halted core ignores every redirect.
  always_comb begin
    tgt_sum  = (pc_src1 ? x_rs1 : br_pc) + (pc_src2 ? imm : XLEN'(4));
    br_tgt   = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~pc_src1};
    target   = trap_valid ? trap_pc : br_tgt;
    br_redir = br_valid & pc_src2;
    redir    = (state_reg != ST_HALT) & (trap_valid | br_redir);
    accept   = fetch_req_reg & fetch_if.fetch_ready;
    flush    = redir | ((state_reg == ST_PEND) & accept);
  end

  // Next-state and next-PC decisions.
  always_comb begin
    state_next     = state_reg;
    fetch_req_next = fetch_req_reg;
    fetch_pc_next  = fetch_pc_reg;
    pend_pc_next   = pend_pc_reg;
    unique case (state_reg)
      ST_BOOT: begin
        fetch_req_next = 1'b1;
        state_next     = ST_RUN;
      end
      ST_RUN: begin
        if (redir && fetch_req_reg && !fetch_if.fetch_ready) begin
          // Outstanding request must hold; park the target until accepted.
          pend_pc_next = target;
          state_next   = ST_PEND;
        end else if (redir) begin
          fetch_pc_next  = target;
          fetch_req_next = 1'b1;
        end else if (halt && (!fetch_req_reg || fetch_if.fetch_ready)) begin
          fetch_req_next = 1'b0;
          state_next     = ST_HALT;
        end else if (accept) begin
          fetch_pc_next  = fetch_pc_reg + XLEN'(4);
          fetch_req_next = !stall;
        end else if (!fetch_req_reg) begin
          fetch_req_next = !stall;
        end
      end
      ST_PEND: begin
        if (redir) begin
          pend_pc_next = target;
        end
        if (accept) begin
          // A redirect arriving on the accept cycle is newer than pend_pc.
          fetch_pc_next  = redir ? target : pend_pc_reg;
          fetch_req_next = 1'b1;
          state_next     = ST_RUN;
        end
      end
      ST_HALT: begin
        fetch_req_next = 1'b0;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State and fetch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_BOOT;
      fetch_req_reg <= 1'b0;
      fetch_pc_reg  <= RESET_PC;
      pend_pc_reg   <= RESET_PC;
    end else begin
      state_reg     <= state_next;
      fetch_req_reg <= fetch_req_next;
      fetch_pc_reg  <= fetch_pc_next;
      pend_pc_reg   <= pend_pc_next;
    end
  end

  assign fetch_if.fetch_req = fetch_req_reg;
  assign fetch_if.fetch_pc  = fetch_pc_reg;
  assign halted             = (state_reg == ST_HALT);

`ifdef PC_SEQ_CTRL_PERF_EN
  logic [31:0] redirect_cnt_reg;
  logic [31:0] stall_cnt_reg;

  // Redirect and stalled-cycle counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_reg <= 32'd0;
      stall_cnt_reg    <= 32'd0;
    end else begin
      if (redir) begin
        redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
      end
      if ((state_reg == ST_RUN) && stall && !redir) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_reg;
  assign stall_cnt    = stall_cnt_reg;
`else
  assign redirect_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios followed by
// randomized traffic compared against a behavioural model of the sequencer.
module tb_pc_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        pc_src1;
  logic        pc_src2;
  logic [63:0] br_pc;
  logic [63:0] x_rs1;
  logic [63:0] imm;
  logic        trap_valid;
  logic [63:0] trap_pc;
  logic        halt;
  logic        flush;
  logic        halted;
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;

  pc_seq_ctrl_if #(.XLEN(64)) ifc ();

  pc_seq_ctrl #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .fetch_if     (ifc.master),
    .br_valid     (br_valid),
    .pc_src1      (pc_src1),
    .pc_src2      (pc_src2),
    .br_pc        (br_pc),
    .x_rs1        (x_rs1),
    .imm          (imm),
    .trap_valid   (trap_valid),
    .trap_pc      (trap_pc),
    .halt         (halt),
    .flush        (flush),
    .halted       (halted),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a small set of flags describing where the sequencer is.
  bit          m_valid = 0;
  bit          m_boot, m_pend_v, m_halt, m_req;
  logic [63:0] m_pc, m_pend;
  logic [31:0] m_rc, m_sc;

  bit          hold_pending = 0;
  logic [63:0] hold_pc;

  task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model_target();
    logic [63:0] s;
    if (trap_valid) return trap_pc;
    s = (pc_src1 ? x_rs1 : br_pc) + (pc_src2 ? imm : 64'd4);
    if (pc_src1) s[0] = 1'b0;
    return s;
  endfunction

  function automatic bit model_redir();
    return !m_halt && (trap_valid || (br_valid && pc_src2));
  endfunction

  function automatic bit model_flush();
    return model_redir() || (m_pend_v && m_req && ifc.fetch_ready);
  endfunction

  task automatic model_update();
    bit          rd, acc;
    logic [63:0] t;
    rd  = model_redir();
    acc = m_req && ifc.fetch_ready;
    t   = model_target();
    if (rst) begin
      m_valid = 1; m_boot = 1; m_pend_v = 0; m_halt = 0; m_req = 0;
      m_pc = RST_PC; m_pend = RST_PC; m_rc = 0; m_sc = 0;
    end else if (m_valid && !m_halt) begin
      if (rd) m_rc++;
      if (!m_boot && !m_pend_v && stall && !rd) m_sc++;
      if (m_boot) begin
        m_boot = 0; m_req = 1;
      end else if (m_pend_v) begin
        if (rd) m_pend = t;
        if (acc) begin
          m_pc = rd ? t : m_pend; m_req = 1; m_pend_v = 0;
        end
      end else if (rd) begin
        if (m_req && !ifc.fetch_ready) begin
          m_pend = t; m_pend_v = 1;
        end else begin
          m_pc = t; m_req = 1;
        end
      end else if (halt && (!m_req || ifc.fetch_ready)) begin
        m_req = 0; m_halt = 1;
      end else if (acc) begin
        m_pc = m_pc + 64'd4; m_req = !stall;
      end else if (!m_req) begin
        m_req = !stall;
      end
    end
  endtask

  // One clock cycle: compare outputs with the model, then advance both.
  task automatic step();
    #1;
    if (m_valid) begin
      check_eq("fetch_req", ifc.fetch_req, m_req);
      check_eq("fetch_pc", ifc.fetch_pc, m_pc);
      check_eq("flush", flush, model_flush());
      check_eq("halted", halted, m_halt);
`ifdef PC_SEQ_CTRL_PERF_EN
      check_eq("redirect_cnt", redirect_cnt, m_rc);
      check_eq("stall_cnt", stall_cnt, m_sc);
`else
      check_eq("redirect_cnt", redirect_cnt, 0);
      check_eq("stall_cnt", stall_cnt, 0);
`endif
      if (hold_pending) begin
        check_eq("hold_req", ifc.fetch_req, 1);
        check_eq("hold_pc", ifc.fetch_pc, hold_pc);
      end
    end
    hold_pending = !rst && (ifc.fetch_req === 1'b1) && (ifc.fetch_ready === 1'b0);
    hold_pc      = ifc.fetch_pc;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    stall = 0; br_valid = 0; pc_src1 = 0; pc_src2 = 0;
    br_pc = '0; x_rs1 = '0; imm = '0;
    trap_valid = 0; trap_pc = '0; halt = 0;
  endtask

  int halt_cycles = 0;

  initial begin
    set_idle();
    rst = 1; ifc.fetch_ready = 0;
    @(posedge clk); #1;
    step(); step();
    check_eq("rst_req", ifc.fetch_req, 0);
    check_eq("rst_pc", ifc.fetch_pc, RST_PC);
    check_eq("rst_halted", halted, 0);

    // Boot and sequential fetch.
    rst = 0; ifc.fetch_ready = 1;
    step();
    check_eq("boot_req", ifc.fetch_req, 1);
    check_eq("boot_pc", ifc.fetch_pc, 64'h8000_0000);
    step();
    check_eq("seq_pc1", ifc.fetch_pc, 64'h8000_0004);
    step();
    check_eq("seq_pc2", ifc.fetch_pc, 64'h8000_0008);
    check_eq("seq_halted", halted, 0);

    // Taken branch with negative offset.
    br_valid = 1; pc_src2 = 1; br_pc = 64'h8000_0010; imm = 64'hFFFF_FFFF_FFFF_FFF8;
    #1 check_eq("br_flush", flush, 1);
    step();
    check_eq("br_pc", ifc.fetch_pc, 64'h8000_0008);

    // JALR clears bit0; not-taken branch causes no redirect.
    set_idle();
    br_valid = 1; pc_src1 = 1; pc_src2 = 1; x_rs1 = 64'h8000_1001; imm = 64'd4;
    step();
    check_eq("jalr_pc", ifc.fetch_pc, 64'h8000_1004);
    pc_src2 = 0;
    #1 check_eq("nt_flush", flush, 0);
    step();
    check_eq("nt_pc", ifc.fetch_pc, 64'h8000_1008);

    // Redirect while a request is stalled by the IFU.
    set_idle();
    trap_valid = 1; trap_pc = 64'h8000_0020;
    step();
    check_eq("to20_pc", ifc.fetch_pc, 64'h8000_0020);
    set_idle(); ifc.fetch_ready = 0;
    br_valid = 1; pc_src2 = 1; br_pc = 64'h8000_00F0; imm = 64'h10;
    #1 check_eq("pend_redir_flush", flush, 1);
    step();
    check_eq("pend_hold_pc", ifc.fetch_pc, 64'h8000_0020);
    set_idle();
    step();
    ifc.fetch_ready = 1;
    #1 check_eq("pend_accept_flush", flush, 1);
    step();
    check_eq("pend_new_pc", ifc.fetch_pc, 64'h8000_0100);
    check_eq("pend_new_req", ifc.fetch_req, 1);

    // Trap beats a same-cycle taken branch.
    trap_valid = 1; trap_pc = 64'h8000_0400;
    br_valid = 1; pc_src2 = 1; br_pc = 64'h8000_01F0; imm = 64'h10;
    step();
    check_eq("trap_prio_pc", ifc.fetch_pc, 64'h8000_0400);

    // Halt waits for the outstanding request, then sticks until reset.
    set_idle(); ifc.fetch_ready = 0; halt = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("halt_wait_req", ifc.fetch_req, 1);
    end
    ifc.fetch_ready = 1;
    step();
    check_eq("halt_req", ifc.fetch_req, 0);
    check_eq("halt_halted", halted, 1);
    set_idle(); br_valid = 1; pc_src2 = 1; trap_valid = 1; trap_pc = 64'h1234;
    #1 check_eq("halt_flush", flush, 0);
    for (int i = 0; i < 3; i++) step();
    check_eq("halt_sticky", halted, 1);
    set_idle(); rst = 1;
    step();
    rst = 0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      rst             = ($urandom_range(0, 299) == 0) || (halt_cycles > 6);
      ifc.fetch_ready = ($urandom_range(0, 9) < 7);
      stall           = ($urandom_range(0, 4) == 0);
      br_valid        = ($urandom_range(0, 5) == 0);
      pc_src1         = $urandom_range(0, 1);
      pc_src2         = $urandom_range(0, 1);
      br_pc           = {$urandom(), $urandom()};
      x_rs1           = {$urandom(), $urandom()};
      imm             = (n % 2 == 0) ? {{32{1'b1}}, $urandom()} : 64'($urandom_range(0, 4095));
      trap_valid      = ($urandom_range(0, 29) == 0);
      trap_pc         = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom(), $urandom()};
      halt            = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
